ajit_acc_copy_engine: RTL and testbench

- Memory-side stage downstream of the accelerator's AFB register block.
- Takes a copy command (source, destination, word count) from the register block and moves 64-bit words through the ACB memory request/response pipes: one read, then one write per word.
- Only one ACB transaction is outstanding at any time.
- Reports busy, done, error and progress back to the register block. Optionally raises ACCELERATOR_INTERRUPT.

---
 rtl/ajit_acc_pkg.sv | 31 +++
 rtl/ajit_acb_req_pack.sv | 21 ++
 rtl/ajit_acc_copy_engine.sv | 200 ++++++++++++++++++++
 tb/tb_ajit_acc_copy_engine.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ajit_acc_pkg.sv
// rtl/ajit_acc_pkg.sv - shared ACB field positions and copy-engine state encoding
package ajit_acc_pkg;

    // ACB memory request word layout
    localparam int ACB_REQ_W  = 110;
    localparam int LOCK_BIT   = 109;
    localparam int RW_BIT     = 108;
    localparam int MASK_MSB   = 107;
    localparam int MASK_LSB   = 100;
    localparam int ADDR_MSB   = 99;
    localparam int ADDR_LSB   = 64;
    localparam int DATA_MSB   = 63;
    localparam int DATA_LSB   = 0;

    // ACB memory response word layout
    localparam int ACB_RSP_W       = 65;
    localparam int ACB_RSP_ERR_BIT = 64;

    localparam logic [7:0] ACB_FULL_MASK = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_RSP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_RSP = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } copy_state_t;

endpackage

// File: rtl/ajit_acb_req_pack.sv
// rtl/ajit_acb_req_pack.sv - packs read/write, address and data into an ACB request word
module ajit_acb_req_pack
    import ajit_acc_pkg::*;
(
    input  logic                     read_i,
    input  logic [ADDR_MSB-ADDR_LSB:0] addr_i,
    input  logic [DATA_MSB-DATA_LSB:0] data_i,
    output logic [ACB_REQ_W-1:0]     req_o
);

    // Full-word, unlocked access; the caller supplies zero data for reads.
    always_comb begin
        req_o                     = '0;
        req_o[LOCK_BIT]           = 1'b0;
        req_o[RW_BIT]             = read_i;
        req_o[MASK_MSB:MASK_LSB]  = ACB_FULL_MASK;
        req_o[ADDR_MSB:ADDR_LSB]  = addr_i;
        req_o[DATA_MSB:DATA_LSB]  = data_i;
    end

endmodule

// File: rtl/ajit_acc_copy_engine.sv
// rtl/ajit_acc_copy_engine.sv - word copy engine over ACB pipes; AJIT_ACC_COPY_IRQ_EN enables the interrupt
module ajit_acc_copy_engine
    import ajit_acc_pkg::*;
#(
    parameter int ADDR_W = 36,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic [ADDR_W-1:0]    cmd_src_addr,
    input  logic [ADDR_W-1:0]    cmd_dst_addr,
    input  logic [CNT_W-1:0]     cmd_word_count,
    input  logic                 status_clear,
    output logic                 status_busy,
    output logic                 status_done,
    output logic                 status_error,
    output logic [CNT_W-1:0]     status_words_done,
    output logic [ACB_REQ_W-1:0] ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
    input  logic                 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
    output logic                 ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
    input  logic [ACB_RSP_W-1:0] ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
    input  logic                 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
    output logic                 ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
    output logic                 ACCELERATOR_INTERRUPT
);

    copy_state_t          state_q;
    logic [ADDR_W-1:0]    src_q;
    logic [ADDR_W-1:0]    dst_q;
    logic [CNT_W-1:0]     remaining_q;
    logic [CNT_W-1:0]     words_done_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic                 req_ack_q;
    logic                 rsp_ack_q;
    logic [ACB_REQ_W-1:0] req_data_q;

    logic                 pack_read;
    logic [ADDR_W-1:0]    pack_addr;
    logic [63:0]          pack_data;
    logic [ACB_REQ_W-1:0] pack_word;

    logic [ADDR_W-1:0]    src_next;
    logic [ADDR_W-1:0]    dst_next;
    logic                 req_xfer;
    logic                 rsp_xfer;
    logic                 rsp_err;

    assign src_next = src_q + ADDR_W'(8);
    assign dst_next = dst_q + ADDR_W'(8);
    assign req_xfer = req_ack_q && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
    assign rsp_xfer = rsp_ack_q && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
    assign rsp_err  = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[ACB_RSP_ERR_BIT];

    // Select the next request to register: first read on start, write after a read
    // response, following read after a write response.
    always_comb begin
        pack_read = 1'b1;
        pack_addr = src_next;
        pack_data = '0;
        case (state_q)
            S_IDLE: begin
                pack_addr = cmd_src_addr & ~ADDR_W'(7);
            end
            S_RD_RSP: begin
                pack_read = 1'b0;
                pack_addr = dst_q;
                pack_data = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[63:0];
            end
            default: ;
        endcase
    end

    ajit_acb_req_pack u_req_pack (
        .read_i (pack_read),
        .addr_i (pack_addr),
        .data_i (pack_data),
        .req_o  (pack_word)
    );

    // Copy sequencer; every output is a register so request data holds steady while ack is up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            remaining_q  <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            req_ack_q    <= 1'b0;
            rsp_ack_q    <= 1'b0;
            req_data_q   <= '0;
        end else begin
            // Sticky flag clear; the DONE/ERROR branches below override it.
            if (status_clear) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        words_done_q <= '0;
                        if (cmd_word_count == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            src_q       <= cmd_src_addr & ~ADDR_W'(7);
                            dst_q       <= cmd_dst_addr & ~ADDR_W'(7);
                            remaining_q <= cmd_word_count;
                            req_data_q  <= pack_word;
                            req_ack_q   <= 1'b1;
                            state_q     <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (req_xfer) begin
                        req_ack_q <= 1'b0;
                        rsp_ack_q <= 1'b1;
                        state_q   <= S_RD_RSP;
                    end
                end
                S_RD_RSP: begin
                    if (rsp_xfer) begin
                        rsp_ack_q <= 1'b0;
                        if (rsp_err) begin
                            state_q <= S_ERROR;
                        end else begin
                            // The request register doubles as the data buffer.
                            req_data_q <= pack_word;
                            req_ack_q  <= 1'b1;
                            state_q    <= S_WR_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (req_xfer) begin
                        req_ack_q <= 1'b0;
                        rsp_ack_q <= 1'b1;
                        state_q   <= S_WR_RSP;
                    end
                end
                S_WR_RSP: begin
                    if (rsp_xfer) begin
                        rsp_ack_q <= 1'b0;
                        if (rsp_err) begin
                            state_q <= S_ERROR;
                        end else begin
                            words_done_q <= words_done_q + CNT_W'(1);
                            remaining_q  <= remaining_q - CNT_W'(1);
                            src_q        <= src_next;
                            dst_q        <= dst_next;
                            if (remaining_q == CNT_W'(1)) begin
                                state_q <= S_DONE;
                            end else begin
                                req_data_q <= pack_word;
                                req_ack_q  <= 1'b1;
                                state_q    <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERROR: begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign status_busy                                  = busy_q;
    assign status_done                                  = done_q;
    assign status_error                                 = error_q;
    assign status_words_done                            = words_done_q;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   = req_data_q;
    assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    = req_ack_q;
    assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  = rsp_ack_q;

`ifdef AJIT_ACC_COPY_IRQ_EN
    assign ACCELERATOR_INTERRUPT = done_q | error_q;
`else
    assign ACCELERATOR_INTERRUPT = 1'b0;
`endif

endmodule

// File: tb/tb_ajit_acc_copy_engine.sv
// tb/tb_ajit_acc_copy_engine.sv - scoreboard bench for ajit_acc_copy_engine
module tb_ajit_acc_copy_engine;

`ifdef AJIT_ACC_COPY_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          cmd_start;
    logic [35:0]   cmd_src_addr;
    logic [35:0]   cmd_dst_addr;
    logic [15:0]   cmd_word_count;
    logic          status_clear;
    logic          status_busy;
    logic          status_done;
    logic          status_error;
    logic [15:0]   status_words_done;
    logic [109:0]  req_data;
    logic          req_req;
    logic          req_ack;
    logic [64:0]   rsp_data;
    logic          rsp_req;
    logic          rsp_ack;
    logic          irq;

    int total;
    int bad;
    int n_req;
    int rsp_num;
    int err_at;
    int stall_left;
    int stable_checks;
    logic [109:0] exp_q[$];

    ajit_acc_copy_engine dut (
        .clk                                         (clk),
        .reset                                       (reset),
        .cmd_start                                   (cmd_start),
        .cmd_src_addr                                (cmd_src_addr),
        .cmd_dst_addr                                (cmd_dst_addr),
        .cmd_word_count                              (cmd_word_count),
        .status_clear                                (status_clear),
        .status_busy                                 (status_busy),
        .status_done                                 (status_done),
        .status_error                                (status_error),
        .status_words_done                           (status_words_done),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  (req_data),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   (req_req),
        .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   (req_ack),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(rsp_data),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req (rsp_req),
        .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack (rsp_ack),
        .ACCELERATOR_INTERRUPT                       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [35:0] a);
        return {16'hA5A5, 12'h000, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [109:0] rd_word(input logic [35:0] a);
        return {1'b0, 1'b1, 8'hFF, a, 64'h0};
    endfunction

    function automatic logic [109:0] wr_word(input logic [35:0] a, input logic [63:0] d);
        return {1'b0, 1'b0, 8'hFF, a, d};
    endfunction

    task automatic push_copy(input logic [35:0] src, input logic [35:0] dst, input int n);
        logic [35:0] s;
        logic [35:0] d;
        s = src & ~36'h7;
        d = dst & ~36'h7;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(rd_word(s));
            exp_q.push_back(wr_word(d, mem_word(s)));
            s = s + 36'd8;
            d = d + 36'd8;
        end
    endtask

    task automatic start(input logic [35:0] src, input logic [35:0] dst, input logic [15:0] cnt);
        @(negedge clk);
        cmd_src_addr   = src;
        cmd_dst_addr   = dst;
        cmd_word_count = cnt;
        cmd_start      = 1'b1;
        @(negedge clk);
        cmd_start      = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        status_clear = 1'b1;
        @(negedge clk);
        status_clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (status_busy !== 1'b0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_finish_in_time"}, (cyc < 400), 1'b1);
    endtask

    // Memory model: zero-latency responder, checks each accepted request against the scoreboard.
    initial begin : memory
        logic         rx;
        logic         sx;
        logic         prev_hold;
        logic [109:0] w;
        logic [109:0] prev_w;
        logic [109:0] e;
        req_req   = 1'b1;
        rsp_req   = 1'b0;
        rsp_data  = '0;
        prev_hold = 1'b0;
        prev_w    = '0;
        forever begin
            @(negedge clk);
            rx = req_req && req_ack;
            sx = rsp_req && rsp_ack;
            w  = req_data;
            if (!reset && req_ack && prev_hold) begin
                stable_checks++;
                chk("req_data_stable", w, prev_w);
            end
            prev_hold = req_ack && !req_req;
            prev_w    = w;
            @(posedge clk);
            #1;
            if (reset) begin
                rsp_req   = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (sx) rsp_req = 1'b0;
                if (rx) begin
                    n_req++;
                    chk("acb_req_expected", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("acb_req_word", w, e);
                    end
                    rsp_num++;
                    rsp_data = {(rsp_num == err_at), (w[108] ? mem_word(w[99:64]) : 64'h0)};
                    rsp_req  = 1'b1;
                end
                if (stall_left > 0) stall_left--;
                req_req = (stall_left == 0);
            end
        end
    end

    initial begin : stimulus
        int cyc;
        int base;
        total          = 0;
        bad            = 0;
        n_req          = 0;
        rsp_num        = 0;
        err_at         = 0;
        stall_left     = 0;
        stable_checks  = 0;
        reset          = 1'b1;
        cmd_start      = 1'b0;
        cmd_src_addr   = '0;
        cmd_dst_addr   = '0;
        cmd_word_count = '0;
        status_clear   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", status_busy, 1'b0);
        chk("rst_done", status_done, 1'b0);
        chk("rst_error", status_error, 1'b0);
        chk("rst_words", status_words_done, 16'd0);
        chk("rst_req_ack", req_ack, 1'b0);
        chk("rst_req_data", req_data, 110'd0);
        chk("rst_rsp_ack", rsp_ack, 1'b0);
        chk("rst_irq", irq, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-count start: no requests, done two cycles after start
        base = n_req;
        start(36'h100, 36'h200, 16'd0);
        chk("cnt0_busy_next", status_busy, 1'b1);
        chk("cnt0_done_early", status_done, 1'b0);
        @(negedge clk);
        chk("cnt0_done", status_done, 1'b1);
        chk("cnt0_busy_end", status_busy, 1'b0);
        chk("cnt0_words", status_words_done, 16'd0);
        chk("cnt0_no_req", n_req - base, 0);
        chk("cnt0_irq", irq, IRQ_EN);
        pulse_clear();
        chk("cnt0_clear_done", status_done, 1'b0);
        chk("cnt0_clear_irq", irq, 1'b0);

        // Three-word copy at full speed
        base = n_req;
        push_copy(36'h1000, 36'h2000, 3);
        start(36'h1000, 36'h2000, 16'd3);
        chk("cp3_busy", status_busy, 1'b1);
        cyc = 1;
        while (status_done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("cp3_cycles", cyc, 14);
        chk("cp3_words", status_words_done, 16'd3);
        chk("cp3_busy_end", status_busy, 1'b0);
        chk("cp3_nreq", n_req - base, 6);
        chk("cp3_sb_empty", exp_q.size(), 0);
        chk("cp3_irq", irq, IRQ_EN);

        // Memory stalls the read request; data must hold and one transfer occur
        pulse_clear();
        base          = n_req;
        stable_checks = 0;
        push_copy(36'h1_2340, 36'h5_6780, 1);
        stall_left = 7;
        req_req    = 1'b0;
        start(36'h1_2345, 36'h5_6787, 16'd1);
        wait_idle("stall");
        chk("stall_checks", (stable_checks >= 5), 1'b1);
        chk("stall_nreq", n_req - base, 2);
        chk("stall_done", status_done, 1'b1);
        chk("stall_words", status_words_done, 16'd1);

        // Error on the second response: abort with nothing counted and no further write
        pulse_clear();
        base    = n_req;
        rsp_num = 0;
        err_at  = 2;
        push_copy(36'h3000, 36'h4000, 1);
        start(36'h3000, 36'h4000, 16'd3);
        wait_idle("err");
        repeat (3) @(negedge clk);
        chk("err_error", status_error, 1'b1);
        chk("err_done", status_done, 1'b0);
        chk("err_busy", status_busy, 1'b0);
        chk("err_words", status_words_done, 16'd0);
        chk("err_nreq", n_req - base, 2);
        chk("err_irq", irq, IRQ_EN);
        err_at = 0;
        pulse_clear();
        chk("err_clear", status_error, 1'b0);
        chk("err_clear_irq", irq, 1'b0);

        // Start during a copy is ignored
        base = n_req;
        push_copy(36'h5000, 36'h6000, 3);
        start(36'h5000, 36'h6000, 16'd3);
        repeat (5) @(negedge clk);
        cmd_src_addr   = 36'h9_9990;
        cmd_dst_addr   = 36'h8_8880;
        cmd_word_count = 16'd9;
        cmd_start      = 1'b1;
        @(negedge clk);
        cmd_start      = 1'b0;
        wait_idle("ign");
        repeat (3) @(negedge clk);
        chk("ign_words", status_words_done, 16'd3);
        chk("ign_nreq", n_req - base, 6);
        chk("ign_done", status_done, 1'b1);

        // Reset during the second word's write request
        base = n_req;
        push_copy(36'h7000, 36'h8000, 1);
        exp_q.push_back(rd_word(36'h7008));
        start(36'h7000, 36'h8000, 16'd3);
        cyc = 0;
        while (!(req_ack === 1'b1 && req_data[108] === 1'b0 && (n_req - base) == 3) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rstmid_reach_wr2", (cyc < 100), 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_busy", status_busy, 1'b0);
        chk("rstmid_req_ack", req_ack, 1'b0);
        chk("rstmid_req_data", req_data, 110'd0);
        chk("rstmid_words", status_words_done, 16'd0);
        chk("rstmid_done", status_done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rstmid_sb_empty", exp_q.size(), 0);

        // Copy after reset, with low address bits ignored and source address wrap
        base = n_req;
        push_copy(36'hF_FFFF_FFF8, 36'h1_0000_0005, 2);
        start(36'hF_FFFF_FFFF, 36'h1_0000_0005, 16'd2);
        wait_idle("wrap");
        chk("wrap_words", status_words_done, 16'd2);
        chk("wrap_done", status_done, 1'b1);
        chk("wrap_nreq", n_req - base, 4);
        chk("wrap_sb_empty", exp_q.size(), 0);
        chk("wrap_irq", irq, IRQ_EN);
        pulse_clear();
        chk("final_clear_done", status_done, 1'b0);
        chk("final_clear_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
